// File: rtl/wb_init_pkg.sv
// Shared types and constants for the Wishbone classic-cycle initiator.
//   state_t      : initiator FSM states
//   wb_req_t     : latched master request (address, data seed, byte select, direction)
//   ADDR_STRIDE  : byte increment between beats of an incrementing burst
//   RST_*        : reset values of the master-side outputs
package wb_init_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    typedef struct packed {
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } wb_req_t;

    localparam logic [ADR_W-1:0] ADDR_STRIDE = ADR_W'(4);

    localparam logic             RST_WE  = 1'b0;
    localparam logic [SEL_W-1:0] RST_SEL = '0;
    localparam logic [ADR_W-1:0] RST_ADR = '0;
    localparam logic [DAT_W-1:0] RST_DAT = '0;
    localparam wb_req_t          RST_REQ = '{we: RST_WE, sel: RST_SEL, adr: RST_ADR, dat: RST_DAT};

    // Word-align a byte address; the two low bits never reach the bus.
    function automatic logic [ADR_W-1:0] word_align(input logic [ADR_W-1:0] a);
        return a & ~ADR_W'(3);
    endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Per-beat acknowledge watchdog.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : restart the count (command accept or ack)
//   enable   : count this cycle (a beat is outstanding and not acked)
//   expired  : count has reached TIMEOUT; constant 0 when TIMEOUT is 0
module wb_ack_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_counter
            localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

            logic [CNT_W-1:0] count_q;

            // Saturates at TIMEOUT so expired stays asserted until cleared.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_q <= '0;
                end else if (clear) begin
                    count_q <= '0;
                end else if (enable && !expired) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end

            assign expired = (count_q == CNT_W'(TIMEOUT));
        end
    endgenerate

endmodule

// File: rtl/wb_la_initiator.sv
// Wishbone classic-cycle bus master driven by a simple command port.
// Issues single or incrementing-burst reads/writes; each beat is guarded
// by an ack watchdog so an unresponsive slave aborts the burst with err.
//   wb_clk_i, wb_rst_i     : clock, asynchronous active-high reset
//   cmd_*                  : command handshake and fields (len = beats-1)
//   wbm_*_o / wbm_*_i      : Wishbone master outputs / slave response
//   rsp_valid, rsp_dat     : one pulse per read beat with captured data
//   done, err, busy        : completion pulse, timeout pulse, in-progress
module wb_la_initiator
    import wb_init_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned LEN_W   = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [DAT_W-1:0] cmd_dat,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic [LEN_W-1:0] cmd_len,

    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [SEL_W-1:0] wbm_sel_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    input  logic [DAT_W-1:0] wbm_dat_i,
    input  logic             wbm_ack_i,

    output logic             rsp_valid,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             done,
    output logic             err,
    output logic             busy
);

    state_t           state_q, state_d;
    wb_req_t          req_q, req_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             xfer_q;
    logic             ready_q;

    logic             accept_c;
    logic             ack_c;
    logic             expired;

    // Ack only counts while a strobe is actually on the bus.
    assign ack_c = wbm_ack_i & xfer_q;

    wb_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (accept_c | ack_c),
        .enable  ((state_q == XFER) & ~ack_c),
        .expired (expired)
    );

    // Next-state, datapath updates and response pulses.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        len_d       = len_q;
        beat_d      = beat_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_valid_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        accept_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept_c  = 1'b1;
                    state_d   = XFER;
                    req_d.we  = cmd_we;
                    req_d.sel = cmd_sel;
                    req_d.adr = word_align(cmd_adr);
                    req_d.dat = cmd_dat;
                    len_d     = cmd_len;
                    beat_d    = '0;
                end
            end
            XFER: begin
                if (ack_c) begin
                    // Address wraps naturally at the top of the 32-bit space.
                    req_d.adr = req_q.adr + ADDR_STRIDE;
                    req_d.dat = req_q.dat + DAT_W'(1);
                    if (!req_q.we) begin
                        rsp_valid_d = 1'b1;
                        rsp_dat_d   = wbm_dat_i;
                    end
                    if (beat_q == len_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end else if (expired) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            req_q       <= RST_REQ;
            len_q       <= '0;
            beat_q      <= '0;
            rsp_dat_q   <= '0;
            rsp_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            xfer_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_valid_q <= rsp_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            xfer_q      <= (state_d == XFER);
            ready_q     <= (state_d == IDLE);
        end
    end

    // cyc, stb and busy share one register: all three span exactly the burst.
    assign wbm_cyc_o = xfer_q;
    assign wbm_stb_o = xfer_q;
    assign busy      = xfer_q;
    assign cmd_ready = ready_q;
    assign wbm_we_o  = req_q.we;
    assign wbm_sel_o = req_q.sel;
    assign wbm_adr_o = req_q.adr;
    assign wbm_dat_o = req_q.dat;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
